// File: rtl/alien_fire_controller.sv
// Alien fire controller: picks an armed alien (random start column, one column
// probed per cycle), computes its muzzle position and offers the shot to the
// bullet block over a valid/ready handshake, paced by a cooldown counter.
module alien_fire_controller #(
    parameter int unsigned NUM_ROWS        = 3,
    parameter int unsigned NUM_COLUMNS     = 5,
    parameter int unsigned ALIEN_SPACING_X = 64,
    parameter int unsigned ALIEN_SPACING_Y = 32,
    parameter int unsigned START_X         = 100,
    parameter int unsigned START_Y         = 50,
    parameter int unsigned ALIEN_WIDTH     = 32,
    parameter int unsigned ALIEN_HEIGHT    = 16,
    parameter int unsigned FIRE_COOLDOWN   = 3000,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  enable,
    input  logic [NUM_ROWS-1:0][NUM_COLUMNS-1:0]  armed_matrix,
    input  logic [15:0]                           offset_x,
    input  logic [15:0]                           offset_y,
    input  logic                                  shot_ready,
    output logic                                  shot_valid,
    output logic [15:0]                           shot_x,
    output logic [15:0]                           shot_y,
    output logic [15:0]                           shot_row,
    output logic [15:0]                           shot_column
);

    localparam int unsigned COL_W = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1;
    localparam int unsigned ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam logic [31:0] COOL_RELOAD = (FIRE_COOLDOWN == 0) ? 32'd1 : 32'(FIRE_COOLDOWN);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLUMNS - 1);
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SELECT = 2'd1,
        S_SCAN   = 2'd2,
        S_ISSUE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [31:0]       cooldown;
    logic [31:0]       cooldown_nxt;
    logic [15:0]       lfsr;
    logic [15:0]       lfsr_nxt;
    logic [COL_W-1:0]  cur_col;
    logic [COL_W-1:0]  cur_col_nxt;
    logic [COL_W-1:0]  start_col;
    logic [COL_W-1:0]  probes;
    logic [COL_W-1:0]  probes_nxt;
    logic              col_hit;
    logic [ROW_W-1:0]  hit_row;
    logic [15:0]       muzzle_x;
    logic [15:0]       muzzle_y;
    logic              valid_nxt;
    logic              load_shot;

    // Galois LFSR step and random search start column
    assign lfsr_nxt  = (lfsr >> 1) ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
    assign start_col = COL_W'(32'(lfsr[7:0]) % NUM_COLUMNS);

    // Highest-index armed row in the column currently probed
    always_comb begin
        col_hit = 1'b0;
        hit_row = '0;
        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            if (armed_matrix[r][cur_col]) begin
                col_hit = 1'b1;
                hit_row = ROW_W'(r);
            end
        end
    end

    // Muzzle coordinates of the candidate alien, modulo 2^16
    assign muzzle_x = 16'(START_X) + 16'(16'(cur_col) * 16'(ALIEN_SPACING_X))
                    + offset_x + 16'(ALIEN_WIDTH / 2);
    assign muzzle_y = 16'(START_Y) + 16'(16'(hit_row) * 16'(ALIEN_SPACING_Y))
                    + offset_y + 16'(ALIEN_HEIGHT);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (enable && cooldown == 32'd0) state_nxt = S_SELECT;
            S_SELECT: state_nxt = S_SCAN;
            S_SCAN: begin
                if (!enable)               state_nxt = S_IDLE;
                else if (col_hit)          state_nxt = S_ISSUE;
                else if (probes == LAST_COL) state_nxt = S_IDLE;
            end
            S_ISSUE:  if (shot_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Control outputs: next values for the counters and the shot register
    always_comb begin
        cooldown_nxt = cooldown;
        cur_col_nxt  = cur_col;
        probes_nxt   = probes;
        valid_nxt    = shot_valid;
        load_shot    = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable && cooldown != 32'd0) cooldown_nxt = cooldown - 32'd1;
            end
            S_SELECT: begin
                cur_col_nxt = start_col;
                probes_nxt  = '0;
            end
            S_SCAN: begin
                if (!enable) begin
                    cooldown_nxt = 32'd0;
                end else if (col_hit) begin
                    load_shot = 1'b1;
                    valid_nxt = 1'b1;
                end else if (probes == LAST_COL) begin
                    cooldown_nxt = COOL_RELOAD;
                end else begin
                    cur_col_nxt = (cur_col == LAST_COL) ? '0 : cur_col + COL_W'(1);
                    probes_nxt  = probes + COL_W'(1);
                end
            end
            S_ISSUE: begin
                if (shot_ready) begin
                    valid_nxt    = 1'b0;
                    cooldown_nxt = COOL_RELOAD;
                end
            end
            default: valid_nxt = 1'b0;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cooldown    <= COOL_RELOAD;
            lfsr        <= LFSR_SEED;
            cur_col     <= '0;
            probes      <= '0;
            shot_valid  <= 1'b0;
            shot_x      <= '0;
            shot_y      <= '0;
            shot_row    <= '0;
            shot_column <= '0;
        end else begin
            cooldown   <= cooldown_nxt;
            lfsr       <= lfsr_nxt;
            cur_col    <= cur_col_nxt;
            probes     <= probes_nxt;
            shot_valid <= valid_nxt;
            if (load_shot) begin
                shot_x      <= muzzle_x;
                shot_y      <= muzzle_y;
                shot_row    <= 16'(hit_row);
                shot_column <= 16'(cur_col);
            end
        end
    end

endmodule

// File: tb/tb_alien_fire_controller.sv
// Bench for alien_fire_controller: directed scenarios plus randomized traffic,
// all checked every cycle against a behavioural model of the firing rules.
module tb_alien_fire_controller;

    localparam int NR = 3;
    localparam int NC = 5;
    localparam int CD = 4;

    logic                 clk;
    logic                 rst;
    logic                 enable;
    logic [NR-1:0][NC-1:0] armed;
    logic [15:0]          offset_x;
    logic [15:0]          offset_y;
    logic                 shot_ready;
    logic                 shot_valid;
    logic [15:0]          shot_x;
    logic [15:0]          shot_y;
    logic [15:0]          shot_row;
    logic [15:0]          shot_column;

    int n_tests = 0;
    int n_fail  = 0;

    alien_fire_controller #(
        .NUM_ROWS(NR), .NUM_COLUMNS(NC), .FIRE_COOLDOWN(CD)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .armed_matrix(armed),
        .offset_x(offset_x), .offset_y(offset_y), .shot_ready(shot_ready),
        .shot_valid(shot_valid), .shot_x(shot_x), .shot_y(shot_y),
        .shot_row(shot_row), .shot_column(shot_column)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    localparam int M_WAIT = 0, M_PICK = 1, M_SEARCH = 2, M_OFFER = 3;
    int          m_mode   = M_WAIT;
    int          m_cool   = CD;
    logic [15:0] m_lfsr   = 16'hACE1;
    int          m_start  = 0;
    int          m_probes = 0;
    int          e_valid = 0, e_x = 0, e_y = 0, e_row = 0, e_col = 0;

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic model_edge();
        int c;
        int r;
        if (rst) begin
            m_mode = M_WAIT; m_cool = CD; m_lfsr = 16'hACE1;
            e_valid = 0; e_x = 0; e_y = 0; e_row = 0; e_col = 0;
            return;
        end
        case (m_mode)
            M_WAIT: if (enable) begin
                if (m_cool == 0) m_mode = M_PICK;
                else             m_cool = m_cool - 1;
            end
            M_PICK: begin
                m_start  = int'(m_lfsr[7:0]) % NC;
                m_probes = 0;
                m_mode   = M_SEARCH;
            end
            M_SEARCH: begin
                c = (m_start + m_probes) % NC;
                r = -1;
                for (int k = NR - 1; k >= 0 && r < 0; k--)
                    if (armed[k][c]) r = k;
                if (!enable) begin
                    m_mode = M_WAIT; m_cool = 0;
                end else if (r >= 0) begin
                    e_valid = 1; e_row = r; e_col = c;
                    e_x = (100 + c * 64 + int'(offset_x) + 16) & 'hFFFF;
                    e_y = (50 + r * 32 + int'(offset_y) + 16) & 'hFFFF;
                    m_mode = M_OFFER;
                end else if (m_probes == NC - 1) begin
                    m_mode = M_WAIT; m_cool = CD;
                end else begin
                    m_probes = m_probes + 1;
                end
            end
            default: if (shot_ready) begin
                e_valid = 0; m_mode = M_WAIT; m_cool = CD;
            end
        endcase
        m_lfsr = lfsr_adv(m_lfsr);
    endtask

    // One clock: advance the model on the edge, compare just after it
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("valid", 32'(shot_valid), 32'(e_valid));
        check_eq("x",     32'(shot_x),     32'(e_x));
        check_eq("y",     32'(shot_y),     32'(e_y));
        check_eq("row",   32'(shot_row),   32'(e_row));
        check_eq("col",   32'(shot_column), 32'(e_col));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (shot_valid !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        if (shot_valid !== 1'b1) check_eq("wait_valid_timeout", 32'(shot_valid), 32'd1);
    endtask

    function automatic int first_col_after_reset();
        logic [15:0] v;
        v = 16'hACE1;
        for (int i = 0; i < CD + 1; i++) v = lfsr_adv(v);
        return int'(v[7:0]) % NC;
    endfunction

    initial begin
        int n;
        int shots;
        int cyc;
        logic [NC-1:0] seen;

        rst = 1'b1; enable = 1'b1; armed = '0;
        offset_x = '0; offset_y = '0; shot_ready = 1'b1;

        // Reset state and first-shot latency with every alien armed
        armed = '1;
        do_reset();
        check_eq("rst_valid", 32'(shot_valid), 32'd0);
        check_eq("rst_x",     32'(shot_x),     32'd0);
        check_eq("rst_col",   32'(shot_column), 32'd0);
        wait_valid(50, n);
        check_eq("latency", 32'(n), 32'd7);
        check_eq("first_col_lfsr", 32'(shot_column), 32'(first_col_after_reset()));
        tick();
        check_eq("valid_one_cycle", 32'(shot_valid), 32'd0);
        wait_valid(50, n);
        check_eq("rearm_gap", 32'(n + 1), 32'd8);

        // Single armed alien (row 2, col 3), held off by shot_ready=0
        armed = '0; armed[2][3] = 1'b1; shot_ready = 1'b0;
        do_reset();
        wait_valid(60, n);
        check_eq("b_x", 32'(shot_x), 32'd308);
        check_eq("b_y", 32'(shot_y), 32'd130);
        check_eq("b_row", 32'(shot_row), 32'd2);
        check_eq("b_col", 32'(shot_column), 32'd3);
        armed = '0;
        for (int i = 0; i < 20; i++) begin
            enable = i[0];
            tick();
            check_eq("stall_valid", 32'(shot_valid), 32'd1);
            check_eq("stall_x", 32'(shot_x), 32'd308);
            check_eq("stall_y", 32'(shot_y), 32'd130);
            check_eq("stall_row", 32'(shot_row), 32'd2);
            check_eq("stall_col", 32'(shot_column), 32'd3);
        end
        enable = 1'b1; shot_ready = 1'b1;
        tick();
        check_eq("stall_accept", 32'(shot_valid), 32'd0);

        // Nothing armed: never fires
        armed = '0;
        do_reset();
        shots = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (shot_valid) shots++;
        end
        check_eq("empty_no_shot", 32'(shots), 32'd0);

        // Column 1 rows 0 and 2, negative x offset
        armed = '0; armed[0][1] = 1'b1; armed[2][1] = 1'b1;
        offset_x = 16'hFFF0; offset_y = 16'd8;
        do_reset();
        wait_valid(60, n);
        check_eq("e_row", 32'(shot_row), 32'd2);
        check_eq("e_col", 32'(shot_column), 32'd1);
        check_eq("e_x",   32'(shot_x), 32'd164);
        check_eq("e_y",   32'(shot_y), 32'd138);
        offset_x = '0; offset_y = '0;

        // enable low in IDLE freezes the countdown
        armed = '1;
        do_reset();
        ticks(2);
        enable = 1'b0;
        ticks(10);
        enable = 1'b1;
        wait_valid(50, n);
        check_eq("freeze_latency", 32'(n), 32'd5);

        // enable dropped in SCAN (cycle 6): restart at once when enable returns
        do_reset();
        ticks(6);
        enable = 1'b0;
        ticks(4);
        check_eq("abort_no_valid", 32'(shot_valid), 32'd0);
        enable = 1'b1;
        wait_valid(50, n);
        check_eq("abort_restart", 32'(n), 32'd3);

        // Reset while a shot is pending drops it and reseeds the LFSR
        shot_ready = 1'b0;
        do_reset();
        wait_valid(50, n);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst_drop_valid", 32'(shot_valid), 32'd0);
        shot_ready = 1'b1;
        wait_valid(50, n);
        check_eq("rst_relatency", 32'(n), 32'd7);
        check_eq("rst_reseed_col", 32'(shot_column), 32'(first_col_after_reset()));

        // 1000 shots, all armed, random ready/enable/offsets
        do_reset();
        shots = 0; seen = '0; cyc = 0;
        while (shots < 1000 && cyc < 60000) begin
            shot_ready = ($urandom_range(0, 3) != 0);
            enable     = ($urandom_range(0, 19) != 0);
            offset_x   = 16'($urandom);
            offset_y   = 16'($urandom);
            if (shot_valid && shot_ready) begin
                shots++;
                if (shot_column < 16'(NC)) seen[shot_column[2:0]] = 1'b1;
            end
            tick();
            cyc++;
        end
        check_eq("shots_done", 32'(shots), 32'd1000);
        check_eq("all_cols_seen", 32'(seen), 32'h1F);

        // Random live armed matrix
        for (int i = 0; i < 2000; i++) begin
            armed      = (NR * NC)'($urandom);
            shot_ready = ($urandom_range(0, 2) != 0);
            enable     = ($urandom_range(0, 15) != 0);
            offset_x   = 16'($urandom);
            offset_y   = 16'($urandom);
            rst        = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
